// File: rtl/sr_cmd_pkg.sv
// Shared debounce FSM state encodings and the counter-width helper.
// Latency/backpressure: none, definitions only.
package sr_cmd_pkg;

    localparam logic [1:0] S_LOW    = 2'd0;
    localparam logic [1:0] S_CHK_HI = 2'd1;
    localparam logic [1:0] S_HIGH   = 2'd2;
    localparam logic [1:0] S_CHK_LO = 2'd3;

    // Smallest width w with 2**w >= value, never less than 1.
    function automatic int cnt_width(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/sr_cmd_debounce_chan.sv
// One button channel: synchroniser, debounce FSM and press strobe.
// Press is registered, SYNC_STAGES+DEBOUNCE_CYCLES edges after first sample; no backpressure.
module debounce_chan
    import sr_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic press
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    // With a one-cycle window the counter must never leave zero.
    localparam logic [CW-1:0] CNT_ENTRY = (DEBOUNCE_CYCLES > 1) ? CW'(1) : '0;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_in;
    logic [1:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   press_d;

    assign sync_in = sync_q[SYNC_STAGES-1];
    assign stable  = (state_q == S_HIGH) || (state_q == S_CHK_LO);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        case (state_q)
            S_LOW: begin
                if (sync_in) begin
                    state_d = S_CHK_HI;
                    cnt_d   = CNT_ENTRY;
                end else begin
                    cnt_d = '0;
                end
            end
            S_CHK_HI: begin
                if (!sync_in) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HIGH: begin
                if (!sync_in) begin
                    state_d = S_CHK_LO;
                    cnt_d   = CNT_ENTRY;
                end else begin
                    cnt_d = '0;
                end
            end
            default: begin
                if (sync_in) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= S_LOW;
            cnt_q   <= '0;
            press   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], raw};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press   <= press_d;
        end
    end

endmodule

// File: rtl/sr_cmd_debounce.sv
// Debounced set/reset command pulses for the SR stage; set wins a same-cycle tie.
// Outputs one cycle after the channel press strobes; no backpressure.
module sr_cmd_debounce
    import sr_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_set_raw,
    input  logic btn_rst_raw,
    output logic s,
    output logic r,
    output logic conflict
);

    logic set_press, rst_press;
    logic set_level_unused, rst_level_unused;

    debounce_chan #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_set_chan (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_set_raw),
        .stable(set_level_unused),
        .press (set_press)
    );

    debounce_chan #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_rst_chan (
        .clk   (clk),
        .rst   (rst),
        .raw   (btn_rst_raw),
        .stable(rst_level_unused),
        .press (rst_press)
    );

    // A reset press colliding with a set press is dropped, never queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s        <= 1'b0;
            r        <= 1'b0;
            conflict <= 1'b0;
        end else begin
            s        <= set_press;
            r        <= rst_press & ~set_press;
            conflict <= set_press & rst_press;
        end
    end

endmodule

// File: tb/tb_sr_cmd_debounce.sv
// Bench for sr_cmd_debounce: directed scenarios plus a random soak against a run-length debounce model.
module tb_sr_cmd_debounce;

    localparam int DEB = 4;
    localparam int SYNC = 2;
    localparam int LAT = SYNC + DEB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_set_raw = 1'b0;
    logic btn_rst_raw = 1'b0;
    logic s, r, conflict;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    int s_cnt, r_cnt, c_cnt, s_at, r_at, c_at;

    // Reference model: a pure delay line for the synchroniser, then "accept a new
    // level after DEB consecutive differing samples", then a one-cycle output register.
    logic [SYNC-1:0] m_pipe [2];
    logic m_stable [2];
    int   m_run [2];
    logic m_acc [2];
    logic exp_s = 1'b0;
    logic exp_r = 1'b0;
    logic exp_c = 1'b0;

    always #5 clk = ~clk;

    sr_cmd_debounce #(
        .DEBOUNCE_CYCLES(DEB),
        .SYNC_STAGES    (SYNC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_set_raw(btn_set_raw),
        .btn_rst_raw(btn_rst_raw),
        .s          (s),
        .r          (r),
        .conflict   (conflict)
    );

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin : model
        logic lvl, raw_v, acc_now;
        for (int ch = 0; ch < 2; ch++) begin
            m_pipe[ch] = '0; m_stable[ch] = 1'b0; m_run[ch] = 0; m_acc[ch] = 1'b0;
        end
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int ch = 0; ch < 2; ch++) begin
                    m_pipe[ch] = '0; m_stable[ch] = 1'b0; m_run[ch] = 0; m_acc[ch] = 1'b0;
                end
                exp_s = 1'b0; exp_r = 1'b0; exp_c = 1'b0;
            end else begin
                exp_s = m_acc[0];
                exp_r = m_acc[1] & ~m_acc[0];
                exp_c = m_acc[0] & m_acc[1];
                for (int ch = 0; ch < 2; ch++) begin
                    raw_v = (ch == 0) ? btn_set_raw : btn_rst_raw;
                    lvl = m_pipe[ch][SYNC-1];
                    acc_now = 1'b0;
                    if (lvl != m_stable[ch]) begin
                        m_run[ch]++;
                        if (m_run[ch] >= DEB) begin
                            m_stable[ch] = lvl;
                            m_run[ch] = 0;
                            acc_now = lvl;
                        end
                    end else begin
                        m_run[ch] = 0;
                    end
                    m_acc[ch] = acc_now;
                    m_pipe[ch] = {m_pipe[ch][SYNC-2:0], raw_v};
                end
            end
        end
    end

    task automatic clear_obs();
        s_cnt = 0; r_cnt = 0; c_cnt = 0;
        s_at = -1; r_at = -1; c_at = -1;
    endtask

    // Observe outputs at the falling edge, then drive the next raw levels.
    task automatic step(input logic set_v, input logic rst_v);
        @(negedge clk);
        if (s) begin s_cnt++; s_at = cyc; end
        if (r) begin r_cnt++; r_at = cyc; end
        if (conflict) begin c_cnt++; c_at = cyc; end
        btn_set_raw = set_v;
        btn_rst_raw = rst_v;
    endtask

    task automatic settle();
        repeat (20) step(1'b0, 1'b0);
        clear_obs();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({s, r, conflict} !== 3'b000) begin
            failures++;
            $display("FAIL reset_outputs got %b want 000", {s, r, conflict});
        end
        clear_obs();
        repeat (10) step(1'b1, 1'b1);
        checks++;
        if (s_cnt + r_cnt + c_cnt != 0) begin
            failures++;
            $display("FAIL reset_held_buttons pulses got %0d want 0", s_cnt + r_cnt + c_cnt);
        end
        step(1'b0, 1'b0);
        rst = 1'b0;
        clear_obs();
        repeat (15) step(1'b0, 1'b0);
        checks++;
        if (s_cnt + r_cnt + c_cnt != 0) begin
            failures++;
            $display("FAIL reset_release_idle pulses got %0d want 0", s_cnt + r_cnt + c_cnt);
        end
    endtask

    task automatic test_clean_press();
        int e;
        clear_obs();
        step(1'b1, 1'b0);
        e = cyc + 1;
        repeat (39) step(1'b1, 1'b0);
        checks++;
        if (s_cnt != 1 || s_at != e + LAT) begin
            failures++;
            $display("FAIL clean_press s count=%0d at=%0d want count=1 at=%0d", s_cnt, s_at, e + LAT);
        end
        checks++;
        if (r_cnt != 0 || c_cnt != 0) begin
            failures++;
            $display("FAIL clean_press_others r=%0d conflict=%0d want 0 0", r_cnt, c_cnt);
        end
        repeat (20) step(1'b0, 1'b0);
        checks++;
        if (s_cnt != 1) begin
            failures++;
            $display("FAIL release_no_cmd s count=%0d want 1", s_cnt);
        end
        settle();
    endtask

    task automatic test_bounce();
        logic [4:0] seq;
        int e;
        seq = 5'b10110;
        clear_obs();
        for (int i = 4; i >= 0; i--) step(1'b0, seq[i]);
        step(1'b0, 1'b1);
        e = cyc + 1;
        repeat (30) step(1'b0, 1'b1);
        checks++;
        if (r_cnt != 1 || r_at != e + LAT) begin
            failures++;
            $display("FAIL bounce r count=%0d at=%0d want count=1 at=%0d", r_cnt, r_at, e + LAT);
        end
        checks++;
        if (s_cnt != 0 || c_cnt != 0) begin
            failures++;
            $display("FAIL bounce_others s=%0d conflict=%0d want 0 0", s_cnt, c_cnt);
        end
        settle();
    endtask

    task automatic test_simultaneous();
        int e;
        clear_obs();
        step(1'b1, 1'b1);
        e = cyc + 1;
        repeat (30) step(1'b1, 1'b1);
        repeat (20) step(1'b0, 1'b0);
        checks++;
        if (s_cnt != 1 || s_at != e + LAT) begin
            failures++;
            $display("FAIL simul_s count=%0d at=%0d want count=1 at=%0d", s_cnt, s_at, e + LAT);
        end
        checks++;
        if (c_cnt != 1 || c_at != e + LAT) begin
            failures++;
            $display("FAIL simul_conflict count=%0d at=%0d want count=1 at=%0d", c_cnt, c_at, e + LAT);
        end
        checks++;
        if (r_cnt != 0) begin
            failures++;
            $display("FAIL simul_r_dropped r count=%0d want 0", r_cnt);
        end
        settle();
    endtask

    task automatic test_release_repress();
        int e2;
        clear_obs();
        repeat (20) step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        repeat (20) step(1'b1, 1'b0);
        checks++;
        if (s_cnt != 1) begin
            failures++;
            $display("FAIL short_release s count=%0d want 1", s_cnt);
        end
        repeat (8) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        e2 = cyc + 1;
        repeat (20) step(1'b1, 1'b0);
        checks++;
        if (s_cnt != 2 || s_at != e2 + LAT) begin
            failures++;
            $display("FAIL repress s count=%0d at=%0d want count=2 at=%0d", s_cnt, s_at, e2 + LAT);
        end
        settle();
    endtask

    task automatic test_reset_mid_count();
        int rr;
        clear_obs();
        repeat (5) step(1'b1, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if ({s, r, conflict} !== 3'b000 || s_cnt != 0) begin
            failures++;
            $display("FAIL midreset_assert outputs=%b s count=%0d want 000 0", {s, r, conflict}, s_cnt);
        end
        @(negedge clk);
        checks++;
        if ({s, r, conflict} !== 3'b000) begin
            failures++;
            $display("FAIL midreset_held outputs=%b want 000", {s, r, conflict});
        end
        rst = 1'b0;
        rr = cyc + 1;
        repeat (20) step(1'b1, 1'b0);
        checks++;
        if (s_cnt != 1 || s_at != rr + LAT) begin
            failures++;
            $display("FAIL midreset_repulse s count=%0d at=%0d want count=1 at=%0d", s_cnt, s_at, rr + LAT);
        end
        settle();
    endtask

    task automatic test_random_soak();
        logic sv, rv, prev_s, prev_r;
        int dut_pulses, mdl_pulses, shown;
        sv = 1'b0; rv = 1'b0; prev_s = 1'b0; prev_r = 1'b0;
        dut_pulses = 0; mdl_pulses = 0; shown = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            checks++;
            if ({s, r, conflict} !== {exp_s, exp_r, exp_c}) begin
                failures++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL soak_model cyc=%0d got s,r,c=%b want %b", cyc, {s, r, conflict}, {exp_s, exp_r, exp_c});
                end
            end
            checks++;
            if ((s & r) !== 1'b0) begin
                failures++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL soak_exclusive cyc=%0d s=%b r=%b want not both", cyc, s, r);
                end
            end
            checks++;
            if ((s && prev_s) || (r && prev_r)) begin
                failures++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL soak_pulse_width cyc=%0d s=%b r=%b held from previous cycle", cyc, s, r);
                end
            end
            if (s || r) dut_pulses++;
            if (exp_s || exp_r) mdl_pulses++;
            prev_s = s;
            prev_r = r;
            if ($urandom_range(0, 5) == 0) sv = ~sv;
            if ($urandom_range(0, 5) == 0) rv = ~rv;
            btn_set_raw = sv;
            btn_rst_raw = rv;
        end
        checks++;
        if (dut_pulses != mdl_pulses || mdl_pulses == 0) begin
            failures++;
            $display("FAIL soak_pulse_total got %0d want %0d (nonzero)", dut_pulses, mdl_pulses);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_release_repress();
        test_reset_mid_count();
        test_random_soak();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
